// File: rtl/reg8_pkg.sv
// Shared constants and types for the 8-bit register load controller.
package reg8_pkg;

  localparam int LARGURA = 8;

  typedef enum logic [1:0] {
    VAZIO = 2'b00,
    CARGA = 2'b01,
    CHEIO = 2'b10
  } estado_t;

  localparam logic OP_CARGA  = 1'b1;
  localparam logic OP_MANTEM = 1'b0;

endpackage

// File: rtl/ControleReg8Bits.sv
// Register control mux: Op=1 passes the A operand, Op=0 returns the held SFF value.
module ControleReg8Bits
  import reg8_pkg::*;
(
  input  logic [LARGURA-1:0] A,
  input  logic [LARGURA-1:0] SFF,
  input  logic               Op,
  output logic [LARGURA-1:0] S
);

  assign S = (Op == OP_CARGA) ? A : SFF;

endmodule

// File: rtl/reg8_ffd.sv
// Eight D flip-flops with asynchronous active-low clear; captures S every edge.
module reg8_ffd
  import reg8_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [LARGURA-1:0] s,
  output logic [LARGURA-1:0] sff
);

  logic [LARGURA-1:0] sff_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sff_q <= '0;
    else        sff_q <= s;
  end

  assign sff = sff_q;

endmodule

// File: rtl/reg8_carga_ctrl.sv
// Load controller around ControleReg8Bits: FSM drives Op, registers A, counts loads.
// Optional parity tracking enabled by defining REG8_PARIDADE_EN.
module reg8_carga_ctrl
  import reg8_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               Wr_valid,
  output logic               Wr_ready,
  input  logic [LARGURA-1:0] Wr_data,
  output logic [LARGURA-1:0] A,
  output logic               Op,
  input  logic [LARGURA-1:0] S,
  output logic [LARGURA-1:0] SFF,
  output logic               Rd_valid,
  input  logic               Rd_ready,
`ifdef REG8_PARIDADE_EN
  output logic               Par,
  input  logic               Wr_par,
  output logic               Err_par,
`endif
  output logic [CNT_W-1:0]   Cnt
);

  estado_t            state_q, state_d;
  logic [LARGURA-1:0] a_q, a_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wr_fire;

  reg8_ffd u_ffd (
    .clk   (Clk),
    .rst_n (Rst_n),
    .s     (S),
    .sff   (SFF)
  );

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= VAZIO;
      a_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      cnt_q   <= cnt_d;
    end
  end

  assign wr_fire = Wr_valid && Wr_ready;

  // NOTE: every signal gets a default before the case so no path infers a latch.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      VAZIO: begin
        if (Wr_valid) begin
          a_d     = Wr_data;
          state_d = CARGA;
        end
      end
      CARGA: begin
        if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + 1'b1;
        state_d = CHEIO;
      end
      CHEIO: begin
        if (Rd_ready) begin
          if (Wr_valid) begin
            a_d     = Wr_data;
            state_d = CARGA;
          end else begin
            state_d = VAZIO;
          end
        end
      end
      default: state_d = VAZIO;
    endcase
  end

  always_comb begin
    Op       = OP_MANTEM;
    Wr_ready = 1'b0;
    Rd_valid = 1'b0;
    unique case (state_q)
      VAZIO:   Wr_ready = 1'b1;
      CARGA:   Op       = OP_CARGA;
      CHEIO: begin
        Rd_valid = 1'b1;
        Wr_ready = Rd_ready;
      end
      default: ;
    endcase
  end

  assign A   = a_q;
  assign Cnt = cnt_q;

`ifdef REG8_PARIDADE_EN
  logic par_q, par_d;
  logic err_par_q, err_par_d;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      par_q     <= 1'b0;
      err_par_q <= 1'b0;
    end else begin
      par_q     <= par_d;
      err_par_q <= err_par_d;
    end
  end

  // Parity follows SFF: it only changes on the edge that loads a new word.
  always_comb begin
    par_d     = (state_q == CARGA) ? ^S : par_q;
    err_par_d = err_par_q | (wr_fire && (Wr_par != ^Wr_data));
  end

  assign Par     = par_q;
  assign Err_par = err_par_q;
`else
  logic unused_wr_fire;
  assign unused_wr_fire = wr_fire;
`endif

endmodule

// File: doc/reg8_carga_ctrl.md
Name: reg8_carga_ctrl

Overview:
- Sequential stage wrapped around the 8-bit register control mux (ControleReg8Bits).
- Holds the 8 D flip-flops whose outputs feed the mux's SFF input, and registers the A operand presented to the mux.
- Drives the mux select Op from a 3-state FSM and feeds the mux output S back into the flip-flops every clock.
- Wraps the register in a one-entry write/read valid-ready buffer and keeps a saturating load counter.

Parameters:
- LARGURA, 8, data width; fixed at 8 to match the mux stage, and kept as a parameter for the package constant only.
- CNT_W, 8, width of the load counter.

Ports:
- Clk  input  1  single system clock, rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- Wr_valid  input  1  write request.
- Wr_ready  output  1  block can accept a write this cycle.
- Wr_data  input  8  write data.
- A  output  8  registered operand to the mux A input.
- Op  output  1  mux select: 1 selects A, 0 selects SFF (hold).
- S  input  8  mux output, next flip-flop value.
- SFF  output  8  flip-flop contents, to the mux SFF input and to the consumer.
- Rd_valid  output  1  SFF holds an unread word.
- Rd_ready  input  1  consumer takes the word.
- Cnt  output  CNT_W  number of completed loads.

Behaviour:
- Reset (asynchronous on Rst_n=0): state=VAZIO, A=0, SFF=0, Cnt=0, Op=0, Rd_valid=0, Wr_ready=1 once reset deasserts.
- SFF <= S on every rising Clk; the hold function comes from Op=0 (mux returns SFF).
- FSM states: VAZIO, CARGA, CHEIO.
- VAZIO: Wr_ready=1, Op=0, Rd_valid=0.
  - Wr_valid=1: A <= Wr_data, go to CARGA.
- CARGA: lasts exactly 1 cycle.
  - Op=1, Wr_ready=0, Rd_valid=0.
  - At the edge: SFF <= S (=A); Cnt <= Cnt+1, saturating at 2^CNT_W-1; go to CHEIO.
- CHEIO: Op=0, Rd_valid=1, Wr_ready=Rd_ready (pass-through).
  - Rd_ready=1, Wr_valid=0: go to VAZIO.
  - Rd_ready=1, Wr_valid=1: A <= Wr_data, go to CARGA; the old word is consumed in the same cycle.
  - Rd_ready=0: stay; SFF, A and Rd_valid are stable.
- Latency: write accepted at edge k; Op=1 during cycle k..k+1; SFF and Rd_valid updated after edge k+1. Write-to-readable is 2 edges.
- Throughput: one word per 2 cycles maximum.
- A changes only on an accepted write. Wr_data is ignored when Wr_ready=0.
- Rd_valid rises only from CARGA, so SFF is never presented mid-load.
- Reset mid-operation (any state): immediate return to reset values; a pending load is discarded and Cnt clears.
- Cnt saturation: at max, further loads leave Cnt unchanged; data path unaffected.

Optional Feature:
- Macro: REG8_PARIDADE_EN.
- With the macro defined:
  - Extra output Par (1 bit) = XOR of SFF, registered alongside SFF from S on the CARGA edge. Reset value 0.
  - Extra input Wr_par (1 bit). In VAZIO or CHEIO, a write with Wr_par != XOR(Wr_data) is still accepted but sets sticky output Err_par=1 until reset.
- Without it: no Par, Wr_par or Err_par ports; behaviour otherwise identical.

Decomposition:
- Shared package reg8_pkg holds:
  - LARGURA=8.
  - State encoding typedef: VAZIO=2'b00, CARGA=2'b01, CHEIO=2'b10.
  - Op encoding constants OP_CARGA=1, OP_MANTEM=0.
- One natural sub-module: reg8_ffd, the 8 D flip-flops with asynchronous active-low clear (S in, SFF out).
- The FSM, A register and counter stay in the top.
- Verification benches instantiate ControleReg8Bits to close the S/SFF loop.

Test Plan:
- Reset then idle: Rst_n pulse low with Wr_valid=0 -> SFF=0x00, Cnt=0, Rd_valid=0, Wr_ready=1, Op=0 for 10 cycles.
- Single write: Wr_data=0xA5 with Wr_valid for 1 cycle -> Op=1 exactly one cycle later, then SFF=0xA5, Rd_valid=1, Cnt=1. With Rd_ready=0, SFF holds 0xA5 for 20 cycles and Wr_ready=0.
- Back-to-back pass-through: in CHEIO with SFF=0x3C, drive Rd_ready=1, Wr_valid=1, Wr_data=0xC3 -> 0x3C read that cycle, Rd_valid=0 for one cycle, then SFF=0xC3, Cnt increments by 1.
- Read without write: in CHEIO, Rd_ready=1, Wr_valid=0 -> VAZIO, Rd_valid=0, SFF keeps its last value, Op stays 0.
- Counter saturation: 260 write/read pairs -> Cnt reaches 255 and stays; the last word reads correctly.
- Reset mid-load: assert Rst_n=0 during CARGA with A=0x7E -> SFF=0x00, A=0x00, Rd_valid=0, no later Rd_valid without a new write.
